layer_sched: RTL and testbench

- Multi-layer sequencer in front of ctrl_core.
- Holds a host-written table of per-layer descriptors and issues one core request per layer.
- Waits for the core's ack to drop and then rise before advancing to the next layer.
- Ping-pongs the image memory between two buffer regions, so each layer's output becomes the next layer's input without host intervention.

---
 rtl/layer_sched_pkg.sv | 34 +++
 rtl/layer_sched_desc_ram.sv | 21 ++
 rtl/layer_sched.sv | 184 ++++++++++++++++++
 tb/tb_layer_sched.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_sched_pkg.sv
// Shared types for the multi-layer sequencer in front of ctrl_core.
package layer_sched_pkg;

   localparam int LWIDTH   = 10;
   localparam int IMGSIZE  = 12;
   localparam int NETSIZE  = 11;
   localparam int LAYERS   = 8;
   localparam int LAYERLOG = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_CHECK,
      S_ISSUE,
      S_ACKLO,
      S_RUN,
      S_DONE
   } state_t;

   typedef struct packed {
      logic [LWIDTH-1:0]  total_out;
      logic [LWIDTH-1:0]  total_in;
      logic [LWIDTH-1:0]  img_size;
      logic [LWIDTH-1:0]  fil_size;
      logic [NETSIZE-1:0] net_addr;
   } layer_desc_t;

   function automatic logic desc_valid(input layer_desc_t d);
      return (d.fil_size != '0) && (d.img_size != '0) &&
             (d.total_in != '0) && (d.total_out != '0) &&
             (d.fil_size <= d.img_size);
   endfunction

endpackage

// File: rtl/layer_sched_desc_ram.sv
// Layer descriptor table: one write port, registered read port, no reset.
module layer_desc_ram
   import layer_sched_pkg::*;
(
   input  logic                clk,
   input  logic                we,
   input  logic [LAYERLOG-1:0] waddr,
   input  layer_desc_t         wdata,
   input  logic [LAYERLOG-1:0] raddr,
   output layer_desc_t         rdata
);

   layer_desc_t mem [LAYERS];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/layer_sched.sv
// Sequences one ctrl_core request per layer descriptor,
// ping-ponging image buffers A/B between consecutive layers.
module layer_sched
   import layer_sched_pkg::*;
(
   input  logic                clk,
   input  logic                xrst,
   input  logic                start,
   input  logic [LAYERLOG:0]   n_layer,
   input  logic [IMGSIZE-1:0]  buf_a_addr,
   input  logic [IMGSIZE-1:0]  buf_b_addr,
   input  logic                abort,
   input  logic                cfg_we,
   input  logic [LAYERLOG-1:0] cfg_addr,
   input  logic [LWIDTH-1:0]   cfg_total_out,
   input  logic [LWIDTH-1:0]   cfg_total_in,
   input  logic [LWIDTH-1:0]   cfg_img_size,
   input  logic [LWIDTH-1:0]   cfg_fil_size,
   input  logic [NETSIZE-1:0]  cfg_net_addr,
   input  logic                core_ack,
   output logic                core_req,
   output logic [LWIDTH-1:0]   core_total_out,
   output logic [LWIDTH-1:0]   core_total_in,
   output logic [LWIDTH-1:0]   core_img_size,
   output logic [LWIDTH-1:0]   core_fil_size,
   output logic [IMGSIZE-1:0]  core_input_addr,
   output logic [IMGSIZE-1:0]  core_output_addr,
   output logic [NETSIZE-1:0]  core_net_addr,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic                desc_err,
   output logic [LAYERLOG-1:0] cur_layer,
   output logic [IMGSIZE-1:0]  result_addr
);

   state_t              state;
   layer_desc_t         cfg_desc;
   layer_desc_t         rd_desc;
   logic [LAYERLOG:0]   n_q;
   logic [IMGSIZE-1:0]  a_q;
   logic [IMGSIZE-1:0]  b_q;
   logic [IMGSIZE-1:0]  last_out;
   logic [LAYERLOG-1:0] layer;
   logic [LAYERLOG:0]   layer_nx;
   logic                abort_q;
   logic                abort_hit;
   logic                is_last;

   assign cfg_desc  = '{total_out: cfg_total_out,
                        total_in:  cfg_total_in,
                        img_size:  cfg_img_size,
                        fil_size:  cfg_fil_size,
                        net_addr:  cfg_net_addr};
   assign cur_layer = layer;
   assign layer_nx  = {1'b0, layer} + {{LAYERLOG{1'b0}}, 1'b1};
   assign is_last   = (layer_nx == n_q);
   assign abort_hit = abort | abort_q;

   layer_desc_ram u_ram (
      .clk   (clk),
      .we    (cfg_we & ~busy),
      .waddr (cfg_addr),
      .wdata (cfg_desc),
      .raddr (layer),
      .rdata (rd_desc)
   );

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state            <= S_IDLE;
         core_req         <= 1'b0;
         core_total_out   <= '0;
         core_total_in    <= '0;
         core_img_size    <= '0;
         core_fil_size    <= '0;
         core_input_addr  <= '0;
         core_output_addr <= '0;
         core_net_addr    <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         aborted          <= 1'b0;
         desc_err         <= 1'b0;
         result_addr      <= '0;
         n_q              <= '0;
         a_q              <= '0;
         b_q              <= '0;
         last_out         <= '0;
         layer            <= '0;
         abort_q          <= 1'b0;
      end else begin
         core_req <= 1'b0;
         done     <= 1'b0;
         if (busy && abort)
            abort_q <= 1'b1;
         unique case (state)
            S_IDLE: begin
               if (start && n_layer == '0) begin
                  aborted     <= 1'b0;
                  desc_err    <= 1'b0;
                  result_addr <= buf_a_addr;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else if (start) begin
                  n_q      <= n_layer;
                  a_q      <= buf_a_addr;
                  b_q      <= buf_b_addr;
                  last_out <= buf_a_addr;
                  aborted  <= 1'b0;
                  desc_err <= 1'b0;
                  abort_q  <= 1'b0;
                  busy     <= 1'b1;
                  layer    <= '0;
                  state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (abort_hit) begin
                  aborted     <= 1'b1;
                  result_addr <= last_out;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (abort_hit) begin
                  aborted     <= 1'b1;
                  result_addr <= last_out;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else if (!desc_valid(rd_desc)) begin
                  desc_err    <= 1'b1;
                  result_addr <= last_out;
                  done        <= 1'b1;
                  state       <= S_DONE;
               end else begin
                  core_total_out   <= rd_desc.total_out;
                  core_total_in    <= rd_desc.total_in;
                  core_img_size    <= rd_desc.img_size;
                  core_fil_size    <= rd_desc.fil_size;
                  core_net_addr    <= rd_desc.net_addr;
                  core_input_addr  <= layer[0] ? b_q : a_q;
                  core_output_addr <= layer[0] ? a_q : b_q;
                  state            <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               core_req <= 1'b1;
               state    <= S_ACKLO;
            end
            S_ACKLO: begin
               if (!core_ack)
                  state <= S_RUN;
            end
            S_RUN: begin
               if (core_ack) begin
                  last_out <= core_output_addr;
                  if (abort_hit) begin
                     aborted     <= 1'b1;
                     result_addr <= core_output_addr;
                     done        <= 1'b1;
                     state       <= S_DONE;
                  end else if (is_last) begin
                     result_addr <= core_output_addr;
                     done        <= 1'b1;
                     state       <= S_DONE;
                  end else begin
                     layer <= layer_nx[LAYERLOG-1:0];
                     state <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_layer_sched.sv
// Directed scoreboard bench for layer_sched with a simple ack-handshake core model.
module tb_layer_sched;
   import layer_sched_pkg::*;

   logic                clk = 1'b0;
   logic                xrst = 1'b0;
   logic                start = 1'b0;
   logic [LAYERLOG:0]   n_layer = '0;
   logic [IMGSIZE-1:0]  buf_a_addr = '0;
   logic [IMGSIZE-1:0]  buf_b_addr = '0;
   logic                abort = 1'b0;
   logic                cfg_we = 1'b0;
   logic [LAYERLOG-1:0] cfg_addr = '0;
   logic [LWIDTH-1:0]   cfg_total_out = '0;
   logic [LWIDTH-1:0]   cfg_total_in = '0;
   logic [LWIDTH-1:0]   cfg_img_size = '0;
   logic [LWIDTH-1:0]   cfg_fil_size = '0;
   logic [NETSIZE-1:0]  cfg_net_addr = '0;
   logic                core_ack = 1'b1;
   logic                core_req;
   logic [LWIDTH-1:0]   core_total_out, core_total_in;
   logic [LWIDTH-1:0]   core_img_size, core_fil_size;
   logic [IMGSIZE-1:0]  core_input_addr, core_output_addr;
   logic [NETSIZE-1:0]  core_net_addr;
   logic                busy, done, aborted, desc_err;
   logic [LAYERLOG-1:0] cur_layer;
   logic [IMGSIZE-1:0]  result_addr;

   layer_sched dut (
      .clk(clk), .xrst(xrst), .start(start), .n_layer(n_layer),
      .buf_a_addr(buf_a_addr), .buf_b_addr(buf_b_addr), .abort(abort),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_total_out(cfg_total_out), .cfg_total_in(cfg_total_in),
      .cfg_img_size(cfg_img_size), .cfg_fil_size(cfg_fil_size),
      .cfg_net_addr(cfg_net_addr), .core_ack(core_ack), .core_req(core_req),
      .core_total_out(core_total_out), .core_total_in(core_total_in),
      .core_img_size(core_img_size), .core_fil_size(core_fil_size),
      .core_input_addr(core_input_addr), .core_output_addr(core_output_addr),
      .core_net_addr(core_net_addr), .busy(busy), .done(done),
      .aborted(aborted), .desc_err(desc_err), .cur_layer(cur_layer),
      .result_addr(result_addr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [IMGSIZE-1:0] in_a;
      logic [IMGSIZE-1:0] out_a;
      layer_desc_t        d;
   } exp_t;

   exp_t        sb[$];
   layer_desc_t tbl [LAYERS];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          req_cnt = 0;
   int          done_cnt = 0;
   int          ack_cnt = 0;
   logic        prev_req = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // core model: ack drops the edge after req, rises 50 cycles later
   always @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         core_ack <= 1'b1;
         ack_cnt  <= 0;
      end else if (core_req) begin
         core_ack <= 1'b0;
         ack_cnt  <= 50;
      end else if (ack_cnt != 0) begin
         ack_cnt <= ack_cnt - 1;
         if (ack_cnt == 1)
            core_ack <= 1'b1;
      end
   end

   always @(negedge clk) begin
      if (xrst && done)
         done_cnt++;
      if (xrst && core_req) begin
         exp_t e;
         req_cnt++;
         chk("req_width", {63'd0, prev_req}, 64'd0);
         if (sb.size() == 0) begin
            chk("req_unexpected", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("in_addr", {52'd0, core_input_addr}, {52'd0, e.in_a});
            chk("out_addr", {52'd0, core_output_addr}, {52'd0, e.out_a});
            chk("params", {13'd0, core_total_out, core_total_in, core_img_size,
                           core_fil_size, core_net_addr}, {13'd0, e.d});
         end
      end
      prev_req = xrst & core_req;
   end

   task automatic wr(input int idx, input int to, input int ti, input int img,
                     input int fil, input int net, input bit model);
      @(negedge clk);
      cfg_we        = 1'b1;
      cfg_addr      = idx[LAYERLOG-1:0];
      cfg_total_out = to[LWIDTH-1:0];
      cfg_total_in  = ti[LWIDTH-1:0];
      cfg_img_size  = img[LWIDTH-1:0];
      cfg_fil_size  = fil[LWIDTH-1:0];
      cfg_net_addr  = net[NETSIZE-1:0];
      if (model)
         tbl[idx] = '{to[LWIDTH-1:0], ti[LWIDTH-1:0], img[LWIDTH-1:0],
                      fil[LWIDTH-1:0], net[NETSIZE-1:0]};
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   function automatic void push(input int idx, input logic [IMGSIZE-1:0] a,
                                input logic [IMGSIZE-1:0] b);
      exp_t e;
      e.in_a  = idx[0] ? b : a;
      e.out_a = idx[0] ? a : b;
      e.d     = tbl[idx];
      sb.push_back(e);
   endfunction

   task automatic go(input int n, input logic [IMGSIZE-1:0] a,
                     input logic [IMGSIZE-1:0] b);
      @(negedge clk);
      start      = 1'b1;
      n_layer    = n[LAYERLOG:0];
      buf_a_addr = a;
      buf_b_addr = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_sig(input string tag, input bit use_done, input int budget);
      int n = 0;
      while (!(use_done ? done : core_req) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {63'd0, use_done ? done : core_req}, 64'd1);
   endtask

   initial begin
      int r0, d0, lat;
      repeat (3) @(negedge clk);
      chk("rst_busy_done", {62'd0, busy, done}, 64'd0);
      chk("rst_req_status", {61'd0, core_req, aborted, desc_err}, 64'd0);
      chk("rst_layer_result", {49'd0, cur_layer, result_addr}, 64'd0);
      xrst = 1'b1;
      wr(0, 4, 3, 12, 5, 'h10, 1);
      wr(1, 6, 4, 8, 3, 'h20, 1);
      wr(2, 2, 6, 6, 3, 'h30, 1);

      // three valid layers with ping-pong addressing
      push(0, 12'h000, 12'h400);
      push(1, 12'h000, 12'h400);
      push(2, 12'h000, 12'h400);
      r0 = req_cnt; d0 = done_cnt;
      @(negedge clk);
      start = 1'b1; n_layer = 4'd3; buf_a_addr = 12'h000; buf_b_addr = 12'h400;
      lat = 0;
      do begin
         @(negedge clk);
         start = 1'b0;
         lat++;
      end while (!core_req && lat < 20);
      chk("req_latency", lat, 4);
      wait_sig("run3_done", 1, 1000);
      chk("run3_result", {52'd0, result_addr}, 64'h400);
      chk("run3_status", {62'd0, aborted, desc_err}, 64'd0);
      @(negedge clk);
      chk("run3_busy_after", {63'd0, busy}, 64'd0);
      chk("run3_reqs", req_cnt - r0, 3);
      chk("run3_dones", done_cnt - d0, 1);

      // zero-layer run
      r0 = req_cnt;
      @(negedge clk);
      start = 1'b1; n_layer = '0; buf_a_addr = 12'h123; buf_b_addr = 12'h456;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", {62'd0, done, busy}, 64'd2);
      chk("zero_result", {52'd0, result_addr}, 64'h123);
      @(negedge clk);
      chk("zero_after", {62'd0, done, busy}, 64'd0);
      chk("zero_reqs", req_cnt - r0, 0);

      // invalid layer 1 (fil > img)
      wr(1, 6, 4, 6, 9, 'h20, 1);
      push(0, 12'h000, 12'h400);
      r0 = req_cnt;
      go(3, 12'h000, 12'h400);
      wait_sig("err_done", 1, 1000);
      chk("err_status", {62'd0, aborted, desc_err}, 64'd1);
      chk("err_result", {52'd0, result_addr}, 64'h400);
      repeat (5) @(negedge clk);
      chk("err_reqs", req_cnt - r0, 1);
      wr(1, 6, 4, 8, 3, 'h20, 1);

      // abort during layer 0
      push(0, 12'h000, 12'h400);
      r0 = req_cnt;
      go(3, 12'h000, 12'h400);
      wait_sig("abort_req", 0, 50);
      repeat (5) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_sig("abort_done", 1, 1000);
      chk("abort_status", {62'd0, aborted, desc_err}, 64'd2);
      chk("abort_result", {52'd0, result_addr}, 64'h400);
      repeat (5) @(negedge clk);
      chk("abort_reqs", req_cnt - r0, 1);

      // cfg_we and start while busy are ignored
      push(0, 12'h000, 12'h400);
      push(1, 12'h000, 12'h400);
      r0 = req_cnt; d0 = done_cnt;
      go(2, 12'h000, 12'h400);
      wait_sig("busy_req", 0, 50);
      repeat (5) @(negedge clk);
      wr(0, 1, 1, 1, 1, 'h7ff, 0);
      start = 1'b1; n_layer = 4'd1;
      @(negedge clk);
      start = 1'b0;
      wait_sig("busy_done", 1, 1000);
      repeat (5) @(negedge clk);
      chk("busy_reqs", req_cnt - r0, 2);
      chk("busy_dones", done_cnt - d0, 1);
      push(0, 12'h000, 12'h400);
      go(1, 12'h000, 12'h400);
      wait_sig("rerun_done", 1, 1000);
      chk("rerun_result", {52'd0, result_addr}, 64'h400);

      // asynchronous reset in S_RUN
      push(0, 12'h000, 12'h400);
      push(1, 12'h000, 12'h400);
      go(2, 12'h000, 12'h400);
      wait_sig("xrst_req", 0, 50);
      repeat (10) @(negedge clk);
      xrst = 1'b0;
      #1;
      chk("xrst_ctl", {61'd0, busy, done, core_req}, 64'd0);
      chk("xrst_status", {49'd0, aborted, desc_err, cur_layer, result_addr}, 64'd0);
      chk("xrst_params", {13'd0, core_total_out, core_total_in, core_img_size,
                          core_fil_size, core_net_addr}, 64'd0);
      chk("xrst_addrs", {40'd0, core_input_addr, core_output_addr}, 64'd0);
      sb.delete();
      @(negedge clk);
      xrst = 1'b1;
      wr(0, 4, 3, 12, 5, 'h10, 1);
      push(0, 12'h200, 12'h600);
      go(1, 12'h200, 12'h600);
      wait_sig("post_rst_done", 1, 1000);
      chk("post_rst_result", {52'd0, result_addr}, 64'h600);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
